// File: rtl/cohort_frame_buffer.sv
// Frame-gated ingress FIFO feeding the cohort serdes: words leave only as whole FRAME-word frames,
// or as a trailing partial frame after flush. Optional zero padding of flushed frames: COHORT_FRAME_BUF_PAD_EN.
module cohort_frame_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  parameter int FRAME = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH) + 1;
  localparam logic [OW-1:0] FRAME_W = OW'(FRAME);
  localparam logic [OW-1:0] DEPTH_W = OW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  if (FRAME < 1 || DEPTH < FRAME || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
    $fatal(1, "cohort_frame_buffer: DEPTH must be a power of 2 >= FRAME, FRAME >= 1");
  end

  typedef enum logic {S_FILL, S_DRAIN} state_t;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [OW-1:0]    r_occ;
  state_t           r_state, w_state_next;
  logic [OW-1:0]    r_beat_cnt, w_beat_cnt_next;
  logic [OW-1:0]    r_frame_len, w_frame_len_next;
  logic             r_flush_pend, w_pend_clr;
  logic             r_flush_frame, w_flush_frame_next;
  logic             w_wr, w_rd, w_beat, w_real;

  assign in_ready  = (r_occ < DEPTH_W);
  assign out_valid = (r_state == S_DRAIN);
  assign occupancy = r_occ;
  assign w_wr      = in_valid & in_ready;
  assign w_beat    = out_valid & out_ready;
  assign out_last  = out_valid & (r_beat_cnt == r_frame_len - OW'(1));
  assign w_rd      = w_beat & w_real;
  assign out_data  = (out_valid & w_real) ? r_mem[r_rd_ptr] : '0;

`ifdef COHORT_FRAME_BUF_PAD_EN
  // Frame length stays FRAME; only the first r_data_len beats carry stored words.
  logic [OW-1:0] r_data_len, w_data_len_next;
  assign w_real = (r_beat_cnt < r_data_len);
`else
  assign w_real = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_beat_cnt_next    = r_beat_cnt;
    w_frame_len_next   = r_frame_len;
    w_flush_frame_next = r_flush_frame;
    w_pend_clr         = 1'b0;
`ifdef COHORT_FRAME_BUF_PAD_EN
    w_data_len_next    = r_data_len;
`endif
    case (r_state)
      S_FILL: begin
        if (r_occ >= FRAME_W) begin
          w_state_next       = S_DRAIN;
          w_frame_len_next   = FRAME_W;
          w_flush_frame_next = 1'b0;
`ifdef COHORT_FRAME_BUF_PAD_EN
          w_data_len_next    = FRAME_W;
`endif
        end else if (r_flush_pend && r_occ != '0) begin
          w_state_next       = S_DRAIN;
          w_flush_frame_next = 1'b1;
`ifdef COHORT_FRAME_BUF_PAD_EN
          w_frame_len_next   = FRAME_W;
          w_data_len_next    = r_occ;
`else
          w_frame_len_next   = r_occ;
`endif
        end else if (r_flush_pend) begin
          w_pend_clr = 1'b1;
        end
      end
      S_DRAIN: begin
        if (w_beat) begin
          if (out_last) begin
            w_beat_cnt_next = '0;
            w_state_next    = S_FILL;
            w_pend_clr      = r_flush_frame;
          end else begin
            w_beat_cnt_next = r_beat_cnt + OW'(1);
          end
        end
      end
      default: w_state_next = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_occ         <= '0;
      r_state       <= S_FILL;
      r_beat_cnt    <= '0;
      r_frame_len   <= FRAME_W;
      r_flush_pend  <= 1'b0;
      r_flush_frame <= 1'b0;
`ifdef COHORT_FRAME_BUF_PAD_EN
      r_data_len    <= FRAME_W;
`endif
    end else begin
      if (w_wr) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
      if (w_rd) r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: r_occ <= r_occ;
      endcase
      r_state       <= w_state_next;
      r_beat_cnt    <= w_beat_cnt_next;
      r_frame_len   <= w_frame_len_next;
      r_flush_frame <= w_flush_frame_next;
      // A new flush pulse wins over a clear in the same cycle.
      r_flush_pend  <= flush | (r_flush_pend & ~w_pend_clr);
`ifdef COHORT_FRAME_BUF_PAD_EN
      r_data_len    <= w_data_len_next;
`endif
    end
  end

endmodule
